// File: rtl/decode_rf.sv
// Y86-64 decode stage: register ID decode, architectural register file with a
// two-write port, forwarding muxes for valA/valB, the E pipeline register and load-use detection.
module decode_rf #(
  parameter int NREG = 15,
  parameter int W    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        Dicode,
  input  logic [3:0]        Difun,
  input  logic [3:0]        DrA,
  input  logic [3:0]        DrB,
  input  logic [W-1:0]      DvalC,
  input  logic [W-1:0]      DvalP,
  input  logic              E_bubble,
  input  logic [3:0]        e_dstE,
  input  logic [W-1:0]      e_valE,
  input  logic [3:0]        MdstE,
  input  logic [3:0]        MdstM,
  input  logic [W-1:0]      MvalE,
  input  logic [W-1:0]      m_valM,
  input  logic [3:0]        WdstE,
  input  logic [3:0]        WdstM,
  input  logic [W-1:0]      WvalE,
  input  logic [W-1:0]      WvalM,
  output logic [3:0]        Eicode,
  output logic [3:0]        Eifun,
  output logic [W-1:0]      EvalC,
  output logic [W-1:0]      EvalA,
  output logic [W-1:0]      EvalB,
  output logic [3:0]        EdstE,
  output logic [3:0]        EdstM,
  output logic [3:0]        EsrcA,
  output logic [3:0]        EsrcB,
  output logic              load_use,
  output logic [NREG*W-1:0] rf_dbg
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [3:0] RSP      = 4'h4;

  logic [W-1:0] rf_q [NREG];

  logic [3:0]   d_srcA, d_srcB, d_dstE, d_dstM;
  logic [W-1:0] d_valA, d_valB;
  logic [3:0]   src_sel [2];
  logic [W-1:0] fwd_val [2];

  logic [3:0]   Eicode_q, Eifun_q, EdstE_q, EdstM_q, EsrcA_q, EsrcB_q;
  logic [W-1:0] EvalC_q, EvalA_q, EvalB_q;
  logic [3:0]   Eicode_d, Eifun_d, EdstE_d, EdstM_d, EsrcA_d, EsrcB_d;
  logic [W-1:0] EvalC_d, EvalA_d, EvalB_d;

  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;
    case (Dicode)
      I_CMOVXX: begin d_srcA = DrA; d_dstE = DrB; end
      I_IRMOVQ: d_dstE = DrB;
      I_RMMOVQ: begin d_srcA = DrA; d_srcB = DrB; end
      I_MRMOVQ: begin d_srcB = DrB; d_dstM = DrA; end
      I_OPQ:    begin d_srcA = DrA; d_srcB = DrB; d_dstE = DrB; end
      I_CALL:   begin d_srcB = RSP; d_dstE = RSP; end
      I_RET:    begin d_srcA = RSP; d_srcB = RSP; d_dstE = RSP; end
      I_PUSHQ:  begin d_srcA = DrA; d_srcB = RSP; d_dstE = RSP; end
      I_POPQ:   begin d_srcA = RSP; d_srcB = RSP; d_dstE = RSP; d_dstM = DrA; end
      default:  ;
    endcase
  end

  assign src_sel[0] = d_srcA;
  assign src_sel[1] = d_srcB;

  // Identical forwarding chain for both read ports; W-stage matches cover same-edge writes.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    always_comb begin
      if (src_sel[gi] == RNONE)       fwd_val[gi] = '0;
      else if (src_sel[gi] == e_dstE) fwd_val[gi] = e_valE;
      else if (src_sel[gi] == MdstM)  fwd_val[gi] = m_valM;
      else if (src_sel[gi] == MdstE)  fwd_val[gi] = MvalE;
      else if (src_sel[gi] == WdstM)  fwd_val[gi] = WvalM;
      else if (src_sel[gi] == WdstE)  fwd_val[gi] = WvalE;
      else                            fwd_val[gi] = rf_q[src_sel[gi]];
    end
  end

  assign d_valA = (Dicode == I_CALL || Dicode == I_JXX) ? DvalP : fwd_val[0];
  assign d_valB = fwd_val[1];

  // M port is written after E port so it wins on a shared destination.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= W'(i);
    end else begin
      if (WdstE != RNONE) rf_q[WdstE] <= WvalE;
      if (WdstM != RNONE) rf_q[WdstM] <= WvalM;
    end
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : g_dbg
    assign rf_dbg[gi*W +: W] = rf_q[gi];
  end

  always_comb begin
    Eicode_d = I_NOP;
    Eifun_d  = 4'h0;
    EvalC_d  = '0;
    EvalA_d  = '0;
    EvalB_d  = '0;
    EdstE_d  = RNONE;
    EdstM_d  = RNONE;
    EsrcA_d  = RNONE;
    EsrcB_d  = RNONE;
    if (!rst && !E_bubble) begin
      Eicode_d = Dicode;
      Eifun_d  = Difun;
      EvalC_d  = DvalC;
      EvalA_d  = d_valA;
      EvalB_d  = d_valB;
      EdstE_d  = d_dstE;
      EdstM_d  = d_dstM;
      EsrcA_d  = d_srcA;
      EsrcB_d  = d_srcB;
    end
  end

  always_ff @(posedge clk) begin
    Eicode_q <= Eicode_d;
    Eifun_q  <= Eifun_d;
    EvalC_q  <= EvalC_d;
    EvalA_q  <= EvalA_d;
    EvalB_q  <= EvalB_d;
    EdstE_q  <= EdstE_d;
    EdstM_q  <= EdstM_d;
    EsrcA_q  <= EsrcA_d;
    EsrcB_q  <= EsrcB_d;
  end

  assign Eicode = Eicode_q;
  assign Eifun  = Eifun_q;
  assign EvalC  = EvalC_q;
  assign EvalA  = EvalA_q;
  assign EvalB  = EvalB_q;
  assign EdstE  = EdstE_q;
  assign EdstM  = EdstM_q;
  assign EsrcA  = EsrcA_q;
  assign EsrcB  = EsrcB_q;

  assign load_use = (Eicode_q == I_MRMOVQ || Eicode_q == I_POPQ) && (EdstM_q != RNONE) &&
                    (EdstM_q == d_srcA || EdstM_q == d_srcB);

endmodule

// File: doc/decode_rf.md
# decode_rf

Y86-64 pipeline decode stage with the architectural register file. Decodes source and destination register IDs from the D-stage instruction and reads operands through two forwarding muxes. Accepts the W-stage write port and latches the E pipeline register. This block is the read/decode end of the register interface whose write end is the write-back stage; it also flags load-use hazards for pipeline control.

## Interface
- NREG, 15: architectural registers; IDs 0..14 are valid, 4'hF = RNONE.
- W, 64: data width.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- Dicode, Difun  in  4 each  D-stage instruction code and function.
- DrA, DrB  in  4 each  D-stage register specifiers.
- DvalC, DvalP  in  64 each  D-stage constant and next PC.
- E_bubble  in  1  load a bubble into the E register on this edge.
- e_dstE  in  4  execute-stage dstE after the cmov condition is applied.
- e_valE  in  64  execute-stage ALU result.
- MdstE, MdstM  in  4 each  memory-stage destinations.
- MvalE, m_valM  in  64 each  M-register valE and memory read data.
- WdstE, WdstM  in  4 each  write-back destinations; these are also the write port.
- WvalE, WvalM  in  64 each  write-back values.
- Eicode, Eifun  out  4 each  E register instruction fields.
- EvalC, EvalA, EvalB  out  64 each  E register operands.
- EdstE, EdstM, EsrcA, EsrcB  out  4 each  E register register IDs.
- load_use  out  1  combinational load-use hazard flag.
- rf_dbg  out  960  register file contents; reg i is at bits [64i+63:64i].

## Operation
- Icodes: 0 HALT, 1 NOP, 2 CMOVXX, 3 IRMOVQ, 4 RMMOVQ, 5 MRMOVQ, 6 OPQ, 7 JXX, 8 CALL, 9 RET, A PUSHQ, B POPQ.
- Any other icode decodes with all IDs = F.
- d_srcA:
  - rA for CMOVXX, RMMOVQ, OPQ, PUSHQ.
  - 4 for POPQ, RET.
  - F otherwise.
- d_srcB:
  - rB for RMMOVQ, MRMOVQ, OPQ.
  - 4 for PUSHQ, POPQ, CALL, RET.
  - F otherwise.
- d_dstE:
  - rB for CMOVXX, IRMOVQ, OPQ.
  - 4 for PUSHQ, POPQ, CALL, RET.
  - F otherwise.
- d_dstM: rA for MRMOVQ, POPQ; F otherwise.
- d_valA:
  - CALL or JXX selects DvalP, with no forwarding.
  - Otherwise forward on srcA. The first match wins, in this order: e_dstE→e_valE, MdstM→m_valM, MdstE→MvalE, WdstM→WvalM, WdstE→WvalE, then the register file.
- d_valB: same priority chain on srcB, with no valP case.
- A source ID of F never matches any destination; the read value is 0.
- Register file write:
  - On each posedge with !rst: if WdstE≠F, rf[WdstE]←WvalE; if WdstM≠F, rf[WdstM]←WvalM.
  - If WdstE==WdstM≠F, WvalM wins.
  - Destination ID F writes nothing.
- E register on each posedge, priority order:
  - rst loads the bubble.
  - E_bubble loads the bubble.
  - Otherwise load {Dicode, Difun, DvalC, d_valA, d_valB, d_dstE, d_dstM, d_srcA, d_srcB}.
- Bubble contents: icode 1, ifun 0, valC/valA/valB 0, all IDs F.
- load_use = (Eicode∈{MRMOVQ, POPQ}) && EdstM≠F && (EdstM==d_srcA || EdstM==d_srcB).
  - External control responds by stalling F/D and asserting E_bubble.

## Timing
- Reset (synchronous):
  - rf[i]←i for i=0..14 (team test convention).
  - E register←bubble, so all E outputs hold bubble values; load_use=0.
- Decode and forwarding are combinational. D-stage inputs appear on the E outputs after the next rising edge (1-cycle latency).
- Same-edge write and read:
  - The value being written this cycle is supplied by W forwarding, not by the stale rf entry.
  - rf updates and the E latch occur on the same edge.
- rst asserted mid-stream discards the in-flight D instruction and all pending writes on that edge.
- E_bubble takes effect on the same edge it is sampled; D inputs for that cycle are dropped.
- rf_dbg reflects rf contents after each edge, with no extra delay.

## Test plan
- Reset then NOP:
  - Stimulus: assert rst, release, present NOP.
  - Required: rf_dbg shows reg i = i; E shows icode 1, all IDs F, values 0; load_use=0.
- OPQ rA=2, rB=3, no forwarding:
  - Required after one edge: EvalA=2, EvalB=3, EdstE=3, EsrcA=2, EsrcB=3.
- Forward priority:
  - Stimulus: OPQ rA=5 with e_dstE=5/e_valE=0x11, MdstE=5/MvalE=0x22, WdstE=5/WvalE=0x33.
  - Required: EvalA=0x11.
  - Drop e_dstE to F: EvalA=0x22. Drop MdstE to F: EvalA=0x33.
- Write port conflict:
  - Stimulus: WdstE=WdstM=7, WvalE=0xAA, WvalM=0xBB for one edge.
  - Required: rf_dbg reg 7=0xBB; WdstE=F/WdstM=F leaves registers unchanged.
- Load-use:
  - Stimulus: MRMOVQ rA=1 latched into E, then D=OPQ rA=1.
  - Required: load_use=1. With E_bubble asserted, the next E shows bubble values.
- CALL and reset priority:
  - CALL with DvalP=0x40: EvalA=0x40, EsrcB=4, EdstE=4.
  - rst and E_bubble both high: bubble loaded and rf restored to reg i = i.
